// File: rtl/ttm4_sequencer.sv
// TTM4 fetch/decode/execute sequencer: three-cycle FETCH -> EXEC -> WRITE control of the A/B/OUT registers.
// Optional single-step mode is enabled with `define TTM4_STEP_EN (adds the STEP input).
module ttm4_sequencer (
  input  logic       CLK,
  input  logic       RST,
  output logic [3:0] ROM_ADDR,
  input  logic [7:0] ROM_DATA,
  input  logic [3:0] LOADBUS,
  output logic [3:0] STOREBUS,
  output logic       nA_OUT,
  output logic       nB_OUT,
  output logic       nIN_OUT,
  output logic       nA_ST,
  output logic       nB_ST,
  output logic       nOUT_ST,
  output logic       CFLAG,
`ifdef TTM4_STEP_EN
  input  logic       STEP,
`endif
  output logic [1:0] dbg_state
);

  // Handshake: there is none; every enable and strobe is a registered level that
  // changes only on CLK, and a strobe low during WRITE means "load on the edge ending WRITE".

  typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1, WRITE = 2'd2} state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_A, SRC_B, SRC_IN} src_t;
  typedef enum logic [1:0] {DST_NONE, DST_A, DST_B, DST_OUT} dst_t;
  typedef enum logic [1:0] {K_ALU, K_NOP, K_JNC, K_JMP} kind_t;

  typedef struct packed {
    dst_t  dst;
    logic  im_zero;
    kind_t kind;
  } dec_t;

  function automatic src_t src_of(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0100: src_of = SRC_A;
      4'b0001, 4'b0101, 4'b1001: src_of = SRC_B;
      4'b0010, 4'b0110: src_of = SRC_IN;
      default: src_of = SRC_NONE;
    endcase
  endfunction

  function automatic dec_t decode(input logic [3:0] op);
    dec_t d;
    d.dst     = DST_NONE;
    d.im_zero = 1'b0;
    d.kind    = K_ALU;
    case (op)
      4'b0000, 4'b0011: d.dst = DST_A;
      4'b0001, 4'b0010: begin
        d.dst     = DST_A;
        d.im_zero = 1'b1;
      end
      4'b0100, 4'b0101, 4'b0111: d.dst = DST_B;
      4'b0110: begin
        d.dst     = DST_B;
        d.im_zero = 1'b1;
      end
      4'b1001: begin
        d.dst     = DST_OUT;
        d.im_zero = 1'b1;
      end
      4'b1011: d.dst = DST_OUT;
      4'b1110: d.kind = K_JNC;
      4'b1111: d.kind = K_JMP;
      default: d.kind = K_NOP;
    endcase
    return d;
  endfunction

  state_t     state;
  logic [3:0] pc;
  logic [7:0] ir;
  logic [3:0] sum;
  logic       carry;
  logic       cflag;

  dec_t       dec;
  src_t       ir_src;
  src_t       rom_src;
  logic [3:0] src_val;
  logic [3:0] im_val;
  logic [4:0] sum_next;
  logic [3:0] pc_next;
  logic       cflag_next;
  logic       go;

`ifdef TTM4_STEP_EN
  assign go = STEP;
`else
  assign go = 1'b1;
`endif

  assign dec     = decode(ir[7:4]);
  assign ir_src  = src_of(ir[7:4]);
  assign rom_src = src_of(ROM_DATA[7:4]);

  // A "none" source ignores LOADBUS entirely; forced-zero IM keeps moves carry-free.
  always_comb begin
    src_val  = (ir_src == SRC_NONE) ? 4'd0 : LOADBUS;
    im_val   = dec.im_zero ? 4'd0 : ir[3:0];
    sum_next = {1'b0, src_val} + {1'b0, im_val};
  end

  always_comb begin
    pc_next    = pc + 4'd1;
    cflag_next = cflag;
    case (dec.kind)
      K_ALU: cflag_next = carry;
      K_JMP: begin
        pc_next    = ir[3:0];
        cflag_next = 1'b0;
      end
      K_JNC: begin
        if (!cflag) pc_next = ir[3:0];
        cflag_next = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= FETCH;
      pc      <= 4'd0;
      ir      <= 8'd0;
      sum     <= 4'd0;
      carry   <= 1'b0;
      cflag   <= 1'b0;
      nA_OUT  <= 1'b1;
      nB_OUT  <= 1'b1;
      nIN_OUT <= 1'b1;
      nA_ST   <= 1'b1;
      nB_ST   <= 1'b1;
      nOUT_ST <= 1'b1;
    end else begin
      case (state)
        FETCH: begin
          // Enables are decoded from ROM_DATA here so they are low for all of EXEC.
          if (go) begin
            ir      <= ROM_DATA;
            nA_OUT  <= (rom_src != SRC_A);
            nB_OUT  <= (rom_src != SRC_B);
            nIN_OUT <= (rom_src != SRC_IN);
            state   <= EXEC;
          end
        end
        EXEC: begin
          nA_OUT  <= 1'b1;
          nB_OUT  <= 1'b1;
          nIN_OUT <= 1'b1;
          sum     <= sum_next[3:0];
          carry   <= sum_next[4];
          nA_ST   <= (dec.dst != DST_A);
          nB_ST   <= (dec.dst != DST_B);
          nOUT_ST <= (dec.dst != DST_OUT);
          state   <= WRITE;
        end
        WRITE: begin
          nA_ST   <= 1'b1;
          nB_ST   <= 1'b1;
          nOUT_ST <= 1'b1;
          pc      <= pc_next;
          cflag   <= cflag_next;
          state   <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign ROM_ADDR  = pc;
  assign STOREBUS  = sum;
  assign CFLAG     = cflag;
  assign dbg_state = state;

endmodule

// File: tb/tb_ttm4_sequencer.sv
// Directed bench for ttm4_sequencer: ROM and A/B/OUT register models, store-strobe scoreboard.
module tb_ttm4_sequencer;

  logic       CLK;
  logic       RST;
  logic [3:0] ROM_ADDR;
  logic [7:0] ROM_DATA;
  logic [3:0] LOADBUS;
  logic [3:0] STOREBUS;
  logic       nA_OUT, nB_OUT, nIN_OUT, nA_ST, nB_ST, nOUT_ST, CFLAG;
  logic [1:0] dbg_state;
`ifdef TTM4_STEP_EN
  logic       STEP;
`endif

  logic [7:0] rom [16];
  logic [3:0] a_reg, b_reg, out_reg;
  logic [3:0] a_init, b_init, in_val;
  logic       init;

  logic [5:0] exp_q[$];
  int checks;
  int passes;

  ttm4_sequencer dut (
    .CLK(CLK), .RST(RST), .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA),
    .LOADBUS(LOADBUS), .STOREBUS(STOREBUS),
    .nA_OUT(nA_OUT), .nB_OUT(nB_OUT), .nIN_OUT(nIN_OUT),
    .nA_ST(nA_ST), .nB_ST(nB_ST), .nOUT_ST(nOUT_ST), .CFLAG(CFLAG),
`ifdef TTM4_STEP_EN
    .STEP(STEP),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset block
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  assign ROM_DATA = rom[ROM_ADDR];
  assign LOADBUS  = !nA_OUT ? a_reg : !nB_OUT ? b_reg : !nIN_OUT ? in_val : 4'hC;

  always @(posedge CLK) begin
    if (init) begin
      a_reg   <= a_init;
      b_reg   <= b_init;
      out_reg <= 4'h0;
    end else begin
      if (!nA_ST)   a_reg   <= STOREBUS;
      if (!nB_ST)   b_reg   <= STOREBUS;
      if (!nOUT_ST) out_reg <= STOREBUS;
    end
  end

  // monitor: pops one expected {dst, value} per store strobe
  always @(negedge CLK) begin
    int ns;
    int ne;
    logic [1:0] dst;
    logic [5:0] exp_v;
    ns = int'(!nA_ST) + int'(!nB_ST) + int'(!nOUT_ST);
    ne = int'(!nA_OUT) + int'(!nB_OUT) + int'(!nIN_OUT);
    if (ns + ne > 0) begin
      checks++;
      if (ns + ne > 1)
        $display("FAIL exclusive: strobes low %0d enables low %0d required total 1", ns, ne);
      else
        passes++;
    end
    if (ns == 1) begin
      dst = !nA_ST ? 2'd1 : !nB_ST ? 2'd2 : 2'd3;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL store_unexpected: dst %0d value %0h required no strobe", dst, STOREBUS);
      end else begin
        exp_v = exp_q.pop_front();
        if ({dst, STOREBUS} !== exp_v)
          $display("FAIL store: dst %0d value %0h required dst %0d value %0h",
                   dst, STOREBUS, exp_v[5:4], exp_v[3:0]);
        else
          passes++;
      end
    end
  end

  // driver tasks
  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) $display("FAIL %s: got %0h required %0h", name, act, expv);
    else passes++;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;
  endtask

  task automatic do_reset();
    RST  = 1'b1;
    init = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST  = 1'b0;
    init = 1'b0;
  endtask

  task automatic push(input logic [1:0] dst, input logic [3:0] v);
    exp_q.push_back({dst, v});
  endtask

  initial begin
    checks = 0;
    passes = 0;
    a_init = 4'h0;
    b_init = 4'h0;
    in_val = 4'h6;
    init   = 1'b1;
    RST    = 1'b1;
`ifdef TTM4_STEP_EN
    STEP   = 1'b1;
`endif
    clear_rom();

    // reset values
    @(posedge CLK);
    @(negedge CLK);
    chk("rst_rom_addr", int'(ROM_ADDR), 0);
    chk("rst_storebus", int'(STOREBUS), 0);
    chk("rst_strobes", int'({nA_OUT, nB_OUT, nIN_OUT, nA_ST, nB_ST, nOUT_ST}), 6'h3F);
    chk("rst_cflag", int'(CFLAG), 0);
    chk("rst_state", int'(dbg_state), 0);

    // MOV A,5
    clear_rom();
    rom[0] = 8'h35;
    push(2'd1, 4'h5);
    do_reset();
    cyc(1); chk("mov_fetch_addr", int'(ROM_ADDR), 0);
    cyc(2); chk("mov_na_st", int'(nA_ST), 0);
    chk("mov_storebus", int'(STOREBUS), 5);
    cyc(1); chk("mov_next_addr", int'(ROM_ADDR), 1);
    chk("mov_cflag", int'(CFLAG), 0);

    // MOV A,E then ADD A,3 -> 1 with carry
    clear_rom();
    rom[0] = 8'h3E;
    rom[1] = 8'h03;
    push(2'd1, 4'hE);
    push(2'd1, 4'h1);
    do_reset();
    cyc(5); chk("add_na_out", int'(nA_OUT), 0);
    cyc(2); chk("add_cflag", int'(CFLAG), 1);
    chk("add_addr", int'(ROM_ADDR), 2);

    // ADD with carry, JNC taken/not taken, JMP
    clear_rom();
    a_init = 4'hF;
    rom[0] = 8'h01;
    rom[1] = 8'hE9;
    rom[2] = 8'hE9;
    rom[9] = 8'hFF;
    push(2'd1, 4'h0);
    do_reset();
    cyc(4);  chk("jnc_pre_cflag", int'(CFLAG), 1);
    cyc(3);  chk("jnc_carry_addr", int'(ROM_ADDR), 2);
    chk("jnc_carry_cflag", int'(CFLAG), 0);
    cyc(3);  chk("jnc_taken_addr", int'(ROM_ADDR), 9);
    chk("jnc_taken_cflag", int'(CFLAG), 0);
    cyc(3);  chk("jmp_addr", int'(ROM_ADDR), 15);

    // PC wrap through NOP at F with carry held
    clear_rom();
    rom[0]  = 8'hFE;
    rom[14] = 8'h01;
    rom[15] = 8'hD0;
    push(2'd1, 4'h0);
    do_reset();
    cyc(4);  chk("wrap_jmp_addr", int'(ROM_ADDR), 14);
    cyc(3);  chk("wrap_at_f", int'(ROM_ADDR), 15);
    chk("wrap_cflag_set", int'(CFLAG), 1);
    cyc(3);  chk("wrap_addr0", int'(ROM_ADDR), 0);
    chk("wrap_cflag_held", int'(CFLAG), 1);

    // IN / MOV / OUT with forced-zero immediates
    clear_rom();
    a_init = 4'h0;
    rom[0] = 8'h2F;
    rom[1] = 8'h40;
    rom[2] = 8'h52;
    rom[3] = 8'h9F;
    rom[4] = 8'hB3;
    rom[5] = 8'h1F;
    rom[6] = 8'h60;
    rom[7] = 8'hF7;
    push(2'd1, 4'h6);
    push(2'd2, 4'h6);
    push(2'd2, 4'h8);
    push(2'd3, 4'h8);
    push(2'd3, 4'h3);
    push(2'd1, 4'h8);
    push(2'd2, 4'h6);
    do_reset();
    cyc(2);  chk("in_nin_out", int'(nIN_OUT), 0);
    cyc(20); chk("io_addr", int'(ROM_ADDR), 7);
    chk("io_cflag", int'(CFLAG), 0);
    chk("io_out_reg", int'(out_reg), 3);
    chk("io_a_reg", int'(a_reg), 8);

    // reset during WRITE of MOV B,7
    clear_rom();
    b_init = 4'h2;
    rom[0] = 8'h77;
    push(2'd2, 4'h7);
    do_reset();
    cyc(3);
    #1 RST = 1'b1;
    #1;
    chk("cut_nb_st", int'(nB_ST), 1);
    chk("cut_addr", int'(ROM_ADDR), 0);
    chk("cut_state", int'(dbg_state), 0);
    @(posedge CLK);
    #1 RST = 1'b0;
    push(2'd2, 4'h7);
    cyc(1);  chk("cut_refetch", int'(ROM_ADDR), 0);
    chk("cut_no_load", int'(b_reg), 2);
    cyc(3);  chk("cut_next_addr", int'(ROM_ADDR), 1);
    chk("cut_b_loaded", int'(b_reg), 7);

`ifdef TTM4_STEP_EN
    // single step
    clear_rom();
    rom[0] = 8'h35;
    rom[1] = 8'h35;
    STEP = 1'b0;
    do_reset();
    cyc(10); chk("step_hold_addr", int'(ROM_ADDR), 0);
    chk("step_hold_state", int'(dbg_state), 0);
    push(2'd1, 4'h5);
    STEP = 1'b1;
    cyc(1);
    STEP = 1'b0;
    cyc(6);  chk("step_one_addr", int'(ROM_ADDR), 1);
    chk("step_one_a", int'(a_reg), 5);
    STEP = 1'b1;
    RST = 1'b1;
    cyc(1);
`endif

    chk("drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
